and_gate: RTL and testbench
===========================

// Module: and_gate
// PURPOSE
// - Registered, parameterisable bitwise AND of two operand vectors with a valid-qualified pipeline.
// - Basic logic primitive for datapaths that need clean, timed gating of bus lanes.
// - WIDTH=1 reduces to a clocked 2-input AND gate: y = a & b.
// PARAMETERS
// - WIDTH        1  operand/result width in bits (1..64)
// - PIPE_STAGES  1  register stages from inputs to outputs (1..4)
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      a/b are valid this cycle
// - a          in   WIDTH  operand A
// - b          in   WIDTH  operand B
// - y          out  WIDTH  registered a & b
// - out_valid  out  1      y is valid this cycle
// - y_all      out  1      AND-reduction of y (1 when every result bit is 1)
// - op_count   out  16     valid ops seen with y_all=1 (present only with AND_GATE_STATS_EN)
// BEHAVIOUR
// - Reset: asynchronous assert and synchronous-to-clk deassert.
// - While rst_n=0, all pipeline registers clear: y=0, out_valid=0, y_all=0, op_count=0.
// - Per stage, the valid bit always advances; data registers load only when the incoming valid=1.
// - Result = a & b, computed combinationally before stage 1.
// - Latency is exactly PIPE_STAGES cycles: a sample taken at edge N appears at edge N+PIPE_STAGES-1 + 1.
// - y and y_all hold their last valid value while out_valid=0. There is no backpressure; a new sample may be accepted every cycle.
// - y_all = &y. It is registered alongside y, so both change on the same edge.
// - If in_valid=0, a and b are ignored and may be X; data registers must not load X.
// - rst_n assertion mid-flight drops all in-flight samples immediately, with no partial output.
// - Width: no extension or truncation. Bit i of y depends only on bit i of a and b.
// - Parameter checks are elaboration-time assertions: WIDTH<1, WIDTH>64, PIPE_STAGES<1, or PIPE_STAGES>4 is a fatal error.
// CONFIGURATION
// - Macro AND_GATE_STATS_EN.
// - Defined: the op_count port exists as a 16-bit counter. It increments on each cycle with out_valid=1 and y_all=1, saturates at 16'hFFFF, and is cleared by rst_n.
// - Undefined: the op_count port and its counter are absent; all other behaviour is identical.
// STRUCTURE
// - Package and_gate_pkg holds:
//   - localparams MAX_WIDTH=64, MAX_STAGES=4, CNT_W=16
//   - typedef cnt_t (logic [CNT_W-1:0])
// - Sub-module and_pipe_stage: one valid+data register slice.
//   - Parameter W.
//   - Ports clk, rst_n, v_i, d_i, v_o, d_o.
//   - Instantiated PIPE_STAGES times via generate. Its data bus carries {y_all, y}.
// TESTING
// - Truth table (WIDTH=1, PIPE_STAGES=1):
//   - Apply a/b = 0/0, 0/1, 1/0, 1/1 with in_valid=1, one per cycle.
//   - Expect y = 0, 0, 0, 1, each one cycle later, with out_valid=1.
// - Bus (WIDTH=8):
//   - a=8'hF0, b=8'h3C -> y=8'h30, y_all=0.
//   - a=b=8'hFF -> y=8'hFF, y_all=1.
// - Latency (PIPE_STAGES=3):
//   - Apply a single in_valid pulse.
//   - Expect out_valid high exactly 3 cycles later, for exactly 1 cycle; y then holds.
// - Reset mid-flight (PIPE_STAGES=3):
//   - Drive rst_n=0 asynchronously one cycle after the pulse.
//   - Expect out_valid=0 and y=0 immediately, and no output emerges after release.
// - Hold/idle: after valid 1&1, drive in_valid=0 with a=X. Expect y to stay 1 and out_valid=0.
// - Stats (AND_GATE_STATS_EN):
//   - 5 ops with y_all=1 and 2 with y_all=0 -> op_count=5.
//   - Preload near 16'hFFFF -> op_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared limits and types for the registered AND-gate pipeline.
package and_gate_pkg;
    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 4;
    localparam int CNT_W      = 16;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/and_pipe_stage.sv
// One valid+data register slice: the valid bit always advances, data loads only with valid.
module and_pipe_stage #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         v_i,
    input  logic [W-1:0] d_i,
    output logic         v_o,
    output logic [W-1:0] d_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_o <= 1'b0;
            d_o <= '0;
        end else begin
            v_o <= v_i;
            if (v_i) d_o <= d_i;
        end
    end
endmodule

// File: rtl/and_gate.sv
// Registered bitwise AND with a valid-qualified pipeline of PIPE_STAGES slices.
// Optional AND_GATE_STATS_EN adds a saturating op_count of valid all-ones results.
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int PIPE_STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic             y_all
`ifdef AND_GATE_STATS_EN
    ,
    output logic [CNT_W-1:0] op_count
`endif
);
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "and_gate: WIDTH out of range");
    end
    if (PIPE_STAGES < 1 || PIPE_STAGES > MAX_STAGES) begin : g_bad_stages
        $fatal(1, "and_gate: PIPE_STAGES out of range");
    end

    logic [WIDTH-1:0]                  res;
    logic [PIPE_STAGES:0]              vld_pipe;
    logic [PIPE_STAGES:0][WIDTH:0]     dat_pipe;

    // y_all rides in the MSB so it is registered on the same edge as y.
    assign res         = a & b;
    assign vld_pipe[0] = in_valid;
    assign dat_pipe[0] = {&res, res};

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        and_pipe_stage #(.W(WIDTH + 1)) u_stage (
            .clk  (clk),
            .rst_n(rst_n),
            .v_i  (vld_pipe[s]),
            .d_i  (dat_pipe[s]),
            .v_o  (vld_pipe[s+1]),
            .d_o  (dat_pipe[s+1])
        );
    end

    assign out_valid = vld_pipe[PIPE_STAGES];
    assign y         = dat_pipe[PIPE_STAGES][WIDTH-1:0];
    assign y_all     = dat_pipe[PIPE_STAGES][WIDTH];

`ifdef AND_GATE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            op_count <= '0;
        else if (out_valid && y_all && op_count != {CNT_W{1'b1}})
            op_count <= op_count + cnt_t'(1);
    end
`endif
endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench: a bus instance (WIDTH=8, 3 stages) and a 1-bit single-stage instance.
module tb_and_gate;
    localparam int W0 = 8;
    localparam int S0 = 3;
    localparam int S1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v0 = 1'b0, v1 = 1'b0;
    logic [W0-1:0] a0 = '0, b0 = '0;
    logic          a1 = 1'b0, b1 = 1'b0;
    logic [W0-1:0] y0;
    logic          y1, ov0, ov1, ya0, ya1;
`ifdef AND_GATE_STATS_EN
    logic [15:0]   cnt0, cnt1;
`endif

    and_gate #(.WIDTH(W0), .PIPE_STAGES(S0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .a(a0), .b(b0),
        .y(y0), .out_valid(ov0), .y_all(ya0)
`ifdef AND_GATE_STATS_EN
        , .op_count(cnt0)
`endif
    );
    and_gate #(.WIDTH(1), .PIPE_STAGES(S1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1),
        .y(y1), .out_valid(ov1), .y_all(ya1)
`ifdef AND_GATE_STATS_EN
        , .op_count(cnt1)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Expected entries: {arrival cycle, y}
    typedef struct { int when; logic [W0-1:0] y; } exp_t;
    exp_t q0[$];
    exp_t q1[$];
    logic [W0-1:0] held0 = '0;
    logic          held1 = 1'b0;
    int            mcnt0 = 0, mcnt1 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of stimulus on both instances and record what must come out.
    task automatic step(input logic iv0, input logic [W0-1:0] ia0, input logic [W0-1:0] ib0,
                        input logic iv1, input logic ia1, input logic ib1);
        exp_t e;
        @(posedge clk); #1;
        v0 = iv0; a0 = ia0; b0 = ib0;
        v1 = iv1; a1 = ia1; b1 = ib1;
        if (iv0) begin e.when = cyc + S0; e.y = ia0 & ib0; q0.push_back(e); end
        if (iv1) begin e.when = cyc + S1; e.y = {7'b0, ia1 & ib1}; q1.push_back(e); end
    endtask

    task automatic idle();
        step(1'b0, 'x, 'x, 1'b0, 1'bx, 1'bx);
    endtask

    // Monitor: compares every output cycle, and checks hold behaviour on idle cycles.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("rst_u0", {ov0, ya0, y0}, '0);
            chk("rst_u1", {ov1, ya1, y1}, '0);
`ifdef AND_GATE_STATS_EN
            chk("rst_cnt0", 64'(cnt0), 64'd0);
`endif
        end else begin
`ifdef AND_GATE_STATS_EN
            chk("op_count0", 64'(cnt0), 64'(mcnt0));
            chk("op_count1", 64'(cnt1), 64'(mcnt1));
`endif
            if (ov0) begin
                if (q0.size() == 0) chk("u0_unexpected_valid", 64'd1, 64'd0);
                else begin
                    e = q0.pop_front();
                    chk("u0_latency", 64'(cyc), 64'(e.when));
                    chk("u0_y", 64'(y0), 64'(e.y));
                    chk("u0_y_all", 64'(ya0), 64'(e.y == {W0{1'b1}}));
                    held0 = e.y;
                    if (e.y == {W0{1'b1}} && mcnt0 < 65535) mcnt0++;
                end
            end else begin
                chk("u0_hold", {ya0, y0}, {held0 == {W0{1'b1}}, held0});
            end
            if (ov1) begin
                if (q1.size() == 0) chk("u1_unexpected_valid", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    chk("u1_latency", 64'(cyc), 64'(e.when));
                    chk("u1_y", 64'(y1), 64'(e.y[0]));
                    chk("u1_y_all", 64'(ya1), 64'(e.y[0]));
                    held1 = e.y[0];
                    if (e.y[0] && mcnt1 < 65535) mcnt1++;
                end
            end else begin
                chk("u1_hold", {ya1, y1}, {held1, held1});
            end
        end
    end

    task automatic do_reset_midflight();
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ov0", 64'(ov0), 64'd0);
        chk("async_rst_y0", 64'(y0), 64'd0);
        q0.delete(); q1.delete();
        held0 = '0; held1 = 1'b0; mcnt0 = 0; mcnt1 = 0;
        v0 = 1'b0; v1 = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W0-1:0] ra, rb;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Truth table on the 1-bit instance, bus vectors on the 8-bit one.
        step(1, 8'hF0, 8'h3C, 1, 0, 0);
        step(1, 8'hFF, 8'hFF, 1, 0, 1);
        step(1, 8'hAA, 8'h55, 1, 1, 0);
        step(1, 8'h0F, 8'hFF, 1, 1, 1);
        repeat (5) idle();

        // Single pulse then idle with X operands: output must hold.
        step(1, 8'hFF, 8'hFF, 1, 1, 1);
        repeat (6) idle();

        // Pulse, then reset one cycle later: nothing may emerge afterwards.
        step(1, 8'hC3, 8'hFF, 1, 1, 1);
        do_reset_midflight();
        repeat (6) idle();

        // Random traffic with a bias toward all-ones results.
        for (int i = 0; i < 300; i++) begin
            ra = W0'($urandom);
            rb = W0'($urandom);
            if ($urandom_range(0, 3) == 0) begin ra = '1; rb = '1; end
            step(1'($urandom_range(0, 1)), ra, rb,
                 1'($urandom_range(0, 1)), ra[0], rb[0]);
        end
        repeat (6) idle();

`ifdef AND_GATE_STATS_EN
        // Count check from a clean start, then drive long enough to saturate.
        do_reset_midflight();
        for (int i = 0; i < 7; i++) step(1, (i < 5) ? 8'hFF : 8'h0F, 8'hFF, 1, (i < 5), 1);
        repeat (6) idle();
        chk("stats_five", 64'(cnt0), 64'd5);
        for (int i = 0; i < 65540; i++) step(1, 8'hFF, 8'hFF, 1, 1, 1);
        repeat (6) idle();
        chk("stats_saturate", 64'(cnt0), 64'hFFFF);
`endif

        chk("u0_drained", 64'(q0.size()), 64'd0);
        chk("u1_drained", 64'(q1.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
